// File: rtl/writeback_unit_if.sv
// Writeback unit bus bundle: ALU offer, load issue/response,
// register-file write port, hazard query and forwarding outputs.
interface writeback_unit_if;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        ld_issue;
   logic [4:0]  ld_issue_rd;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic [2:0]  mem_funct3;
   logic [1:0]  mem_addr_lo;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  chk_rs1;
   logic [4:0]  chk_rs2;
   logic        hazard1;
   logic        hazard2;
   logic        fwd1_valid;
   logic        fwd2_valid;
   logic [31:0] fwd1_data;
   logic [31:0] fwd2_data;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output ld_issue, ld_issue_rd,
      output mem_valid, mem_rd, mem_funct3,
      output mem_addr_lo, mem_rdata,
      output chk_rs1, chk_rs2,
      input  alu_ready, mem_ready,
      input  rf_we, rf_waddr, rf_wdata,
      input  hazard1, hazard2,
      input  fwd1_valid, fwd2_valid,
      input  fwd1_data, fwd2_data
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  ld_issue, ld_issue_rd,
      input  mem_valid, mem_rd, mem_funct3,
      input  mem_addr_lo, mem_rdata,
      input  chk_rs1, chk_rs2,
      output alu_ready, mem_ready,
      output rf_we, rf_waddr, rf_wdata,
      output hazard1, hazard2,
      output fwd1_valid, fwd2_valid,
      output fwd1_data, fwd2_data
   );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: load FIFO with extension, ALU/load arbitration,
// pending-load scoreboard. Optional forwarding: WB_BYPASS_EN.
module writeback_unit #(
   parameter int DEPTH = 2
) (
   input logic            clk,
   input logic            resetn,
   writeback_unit_if.slave wb
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t          q [DEPTH];
   ent_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          alu_fire;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [31:0]   ld_ext;
   logic          sel_any;
   logic          sel_load;
   logic [4:0]    sel_rd;
   logic [31:0]   sel_data;
   logic [31:0]   pending;
   logic [31:0]   pend_set;
   logic [31:0]   pend_clr;
   logic          wb_load;
   logic          match1;
   logic          match2;

   assign wb.mem_ready = count != FULL;
   assign wb.alu_ready = count == '0;
   assign push = wb.mem_valid && wb.mem_ready;
   assign pop = count != '0;
   assign alu_fire = wb.alu_valid && wb.alu_ready;
   assign head = q[rd_ptr];

   // Lane select and sign/zero extension before the FIFO.
   always_comb begin
      unique case (wb.mem_addr_lo)
         2'd0: lane_b = wb.mem_rdata[7:0];
         2'd1: lane_b = wb.mem_rdata[15:8];
         2'd2: lane_b = wb.mem_rdata[23:16];
         2'd3: lane_b = wb.mem_rdata[31:24];
      endcase
      lane_h = wb.mem_addr_lo[1] ? wb.mem_rdata[31:16]
                                 : wb.mem_rdata[15:0];
      case (wb.mem_funct3)
         3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  ld_ext = {24'b0, lane_b};
         3'b101:  ld_ext = {16'b0, lane_h};
         default: ld_ext = wb.mem_rdata;
      endcase
   end

   // Queued loads win; the ALU is served only when the FIFO is empty.
   always_comb begin
      sel_any = 1'b0;
      sel_load = 1'b0;
      sel_rd = '0;
      sel_data = '0;
      if (pop) begin
         sel_any = 1'b1;
         sel_load = 1'b1;
         sel_rd = head.rd;
         sel_data = head.data;
      end else if (alu_fire) begin
         sel_any = 1'b1;
         sel_rd = wb.alu_rd;
         sel_data = wb.alu_data;
      end
   end

   // FIFO storage holds already-extended load data.
   always_ff @(posedge clk) begin
      if (push) q[wr_ptr] <= '{rd: wb.mem_rd, data: ld_ext};
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Registered write port; address/data hold when nothing is selected.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wb.rf_we <= 1'b0;
         wb.rf_waddr <= '0;
         wb.rf_wdata <= '0;
         wb_load <= 1'b0;
      end else begin
         wb.rf_we <= sel_any && (sel_rd != '0);
         if (sel_any) begin
            wb.rf_waddr <= sel_rd;
            wb.rf_wdata <= sel_data;
            wb_load <= sel_load;
         end
      end
   end

   // Scoreboard set/clear masks; a load writeback clears its rd.
   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      if (wb.ld_issue && (wb.ld_issue_rd != '0))
         pend_set = 32'd1 << wb.ld_issue_rd;
      if (wb.rf_we && wb_load)
         pend_clr = 32'd1 << wb.rf_waddr;
   end

   // Pending bits; set beats clear, x0 never pending.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) pending <= '0;
      else pending <= ((pending & ~pend_clr) | pend_set) & ~32'd1;
   end

   // Hazard and forwarding against the current write port.
   always_comb begin
      match1 = wb.rf_we && (wb.rf_waddr == wb.chk_rs1)
               && (wb.chk_rs1 != '0);
      match2 = wb.rf_we && (wb.rf_waddr == wb.chk_rs2)
               && (wb.chk_rs2 != '0);
`ifdef WB_BYPASS_EN
      wb.fwd1_valid = match1;
      wb.fwd2_valid = match2;
      wb.fwd1_data = wb.rf_wdata;
      wb.fwd2_data = wb.rf_wdata;
      wb.hazard1 = (wb.chk_rs1 != '0) && pending[wb.chk_rs1] && !match1;
      wb.hazard2 = (wb.chk_rs2 != '0) && pending[wb.chk_rs2] && !match2;
`else
      wb.fwd1_valid = 1'b0;
      wb.fwd2_valid = 1'b0;
      wb.fwd1_data = '0;
      wb.fwd2_data = '0;
      wb.hazard1 = (wb.chk_rs1 != '0) && (pending[wb.chk_rs1] || match1);
      wb.hazard2 = (wb.chk_rs2 != '0) && (pending[wb.chk_rs2] || match2);
`endif
   end
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: extension table, ALU/load
// ordering scoreboard, collision, fill, rd=0, reset and bypass cases.
module tb_writeback_unit;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic resetn = 1'b1;
   always #5 clk = ~clk;

   writeback_unit_if w();
   writeback_unit #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .resetn(resetn),
      .wb(w)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } res_t;

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [31:0] rdata;
      logic [31:0] exp;
   } vec_t;

   int total = 0;
   int bad = 0;
   res_t mfifo[$];
   res_t sb[$];
   logic [31:0] mpend = '0;
   logic        cur_we = 1'b0;
   logic        cur_load = 1'b0;
   logic [4:0]  cur_waddr = '0;
   logic [31:0] cur_wdata = '0;
   logic [31:0] exp_ld = '0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic m_match(logic [4:0] r);
      return cur_we && (cur_waddr == r) && (r != '0);
   endfunction

   function automatic logic m_haz(logic [4:0] r);
      if (r == '0) return 1'b0;
`ifdef WB_BYPASS_EN
      return mpend[r] && !m_match(r);
`else
      return mpend[r] || m_match(r);
`endif
   endfunction

   function automatic logic m_fwd(logic [4:0] r);
`ifdef WB_BYPASS_EN
      return m_match(r);
`else
      return 1'b0 && (r != r);
`endif
   endfunction

   task automatic idle();
      w.alu_valid = 1'b0;
      w.alu_rd = '0;
      w.alu_data = '0;
      w.ld_issue = 1'b0;
      w.ld_issue_rd = '0;
      w.mem_valid = 1'b0;
      w.mem_rd = '0;
      w.mem_funct3 = '0;
      w.mem_addr_lo = '0;
      w.mem_rdata = '0;
   endtask

   // One clock: check combinational outputs, advance model, check write port.
   task automatic tick();
      res_t sel;
      res_t ent;
      logic have;
      logic sel_load;
      logic full;
      logic [31:0] setm;
      logic [31:0] clrm;
      #1;
      full = mfifo.size() >= DEPTH;
      chk("mem_ready", w.mem_ready, !full);
      chk("alu_ready", w.alu_ready, mfifo.size() == 0);
      chk("hazard1", w.hazard1, m_haz(w.chk_rs1));
      chk("hazard2", w.hazard2, m_haz(w.chk_rs2));
      chk("fwd1_valid", w.fwd1_valid, m_fwd(w.chk_rs1));
      chk("fwd2_valid", w.fwd2_valid, m_fwd(w.chk_rs2));
      chk("fwd1_data", w.fwd1_data, m_fwd(w.chk_rs1) ? cur_wdata : 0);
      chk("fwd2_data", w.fwd2_data, m_fwd(w.chk_rs2) ? cur_wdata : 0);
      have = 1'b0;
      sel_load = 1'b0;
      sel = '{5'd0, 32'd0};
      if (mfifo.size() != 0) begin
         sel = mfifo.pop_front();
         have = 1'b1;
         sel_load = 1'b1;
      end else if (w.alu_valid) begin
         sel = '{w.alu_rd, w.alu_data};
         have = 1'b1;
      end
      if (w.mem_valid && !full) begin
         ent = '{w.mem_rd, exp_ld};
         mfifo.push_back(ent);
      end
      setm = '0;
      clrm = '0;
      if (w.ld_issue && w.ld_issue_rd != 0) setm[w.ld_issue_rd] = 1'b1;
      if (cur_we && cur_load) clrm[cur_waddr] = 1'b1;
      mpend = (mpend & ~clrm) | setm;
      mpend[0] = 1'b0;
      if (have && sel.rd != 0) sb.push_back(sel);
      cur_we = have && (sel.rd != 0);
      if (have) begin
         cur_waddr = sel.rd;
         cur_wdata = sel.data;
         cur_load = sel_load;
      end
      @(posedge clk);
      #1;
      chk("rf_we", w.rf_we, cur_we);
      if (w.rf_we) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got write %h want none", w.rf_waddr);
         end else begin
            ent = sb.pop_front();
            chk("rf_waddr", w.rf_waddr, ent.rd);
            chk("rf_wdata", w.rf_wdata, ent.data);
         end
      end
   endtask

   task automatic do_reset();
      idle();
      resetn = 1'b0;
      #1;
      mfifo.delete();
      sb.delete();
      mpend = '0;
      cur_we = 1'b0;
      cur_load = 1'b0;
      cur_waddr = '0;
      cur_wdata = '0;
      chk("rst_we", w.rf_we, 0);
      chk("rst_waddr", w.rf_waddr, 0);
      chk("rst_wdata", w.rf_wdata, 0);
      chk("rst_alu_ready", w.alu_ready, 1);
      chk("rst_mem_ready", w.mem_ready, 1);
      chk("rst_hazard1", w.hazard1, 0);
      chk("rst_hazard2", w.hazard2, 0);
      chk("rst_fwd1", w.fwd1_valid, 0);
      chk("rst_fwd2", w.fwd2_valid, 0);
      @(posedge clk);
      #1;
      chk("rst_hold_we", w.rf_we, 0);
      resetn = 1'b1;
   endtask

   task automatic drain();
      for (int n = 0; n < 12 && (sb.size() != 0 || mfifo.size() != 0); n++)
         tick();
      chk("drain", sb.size() + mfifo.size(), 0);
   endtask

   vec_t vt[10];
   logic accepted;

   initial begin
      vt[0] = '{3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80};
      vt[1] = '{3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080};
      vt[2] = '{3'b000, 2'd0, 32'h1234_567F, 32'h0000_007F};
      vt[3] = '{3'b000, 2'd3, 32'h80FF_FFFF, 32'hFFFF_FF80};
      vt[4] = '{3'b001, 2'd2, 32'h8001_FFFF, 32'hFFFF_8001};
      vt[5] = '{3'b101, 2'd2, 32'h8001_FFFF, 32'h0000_8001};
      vt[6] = '{3'b001, 2'd0, 32'h0000_7FFF, 32'h0000_7FFF};
      vt[7] = '{3'b010, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vt[8] = '{3'b011, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vt[9] = '{3'b101, 2'd0, 32'h1234_F00D, 32'h0000_F00D};

      idle();
      w.chk_rs1 = '0;
      w.chk_rs2 = '0;
      #1;
      do_reset();

      // Single ALU write, one-cycle pulse, then hold.
      w.alu_valid = 1'b1;
      w.alu_rd = 5'd5;
      w.alu_data = 32'h1234_5678;
      tick();
      chk("alu_we", w.rf_we, 1);
      chk("alu_waddr", w.rf_waddr, 5);
      chk("alu_wdata", w.rf_wdata, 32'h1234_5678);
      idle();
      tick();
      chk("alu_pulse", w.rf_we, 0);
      chk("hold_waddr", w.rf_waddr, 5);
      chk("hold_wdata", w.rf_wdata, 32'h1234_5678);

      // Extension table with pending/hazard tracking.
      for (int i = 0; i < 10; i++) begin
         idle();
         w.chk_rs1 = 5'(i + 7);
         w.ld_issue = 1'b1;
         w.ld_issue_rd = 5'(i + 7);
         tick();
         chk($sformatf("haz_set%0d", i), w.hazard1, 1);
         idle();
         w.mem_valid = 1'b1;
         w.mem_rd = 5'(i + 7);
         w.mem_funct3 = vt[i].f3;
         w.mem_addr_lo = vt[i].lo;
         w.mem_rdata = vt[i].rdata;
         exp_ld = vt[i].exp;
         tick();
         chk($sformatf("lat%0d", i), w.rf_we, 0);
         idle();
         tick();
         chk($sformatf("ld_we%0d", i), w.rf_we, 1);
         chk($sformatf("ext%0d", i), w.rf_wdata, vt[i].exp);
         tick();
         chk($sformatf("pend_clr%0d", i), w.hazard1, 0);
      end
      w.chk_rs1 = '0;

      // Collision: loads queued ahead of a waiting ALU result.
      idle();
      w.mem_valid = 1'b1;
      w.mem_rd = 5'd10;
      w.mem_funct3 = 3'b010;
      w.mem_rdata = 32'hA0A0_0010;
      exp_ld = 32'hA0A0_0010;
      tick();
      w.mem_rd = 5'd11;
      w.mem_rdata = 32'hA0A0_0011;
      exp_ld = 32'hA0A0_0011;
      w.alu_valid = 1'b1;
      w.alu_rd = 5'd12;
      w.alu_data = 32'hB0B0_0012;
      chk("coll_alu_block", w.alu_ready, 0);
      tick();
      w.mem_valid = 1'b0;
      for (int n = 0; n < 8; n++) begin
         accepted = mfifo.size() == 0;
         tick();
         if (accepted) break;
      end
      idle();
      chk("coll_alu_last", w.rf_waddr, 12);
      drain();

      // Fill: DEPTH+1 back-to-back loads honouring mem_ready.
      for (int k = 0; k <= DEPTH; k++) begin
         w.mem_valid = 1'b1;
         w.mem_rd = 5'(20 + k);
         w.mem_funct3 = 3'b010;
         w.mem_addr_lo = 2'(k);
         w.mem_rdata = $urandom;
         exp_ld = w.mem_rdata;
         for (int n = 0; n < 6; n++) begin
            accepted = mfifo.size() < DEPTH;
            tick();
            if (accepted) break;
         end
      end
      idle();
      drain();

      // rd=0 results complete but never write or mark pending.
      w.alu_valid = 1'b1;
      w.alu_rd = '0;
      w.alu_data = 32'hFFFF_FFFF;
      w.ld_issue = 1'b1;
      w.ld_issue_rd = '0;
      tick();
      chk("rd0_alu_we", w.rf_we, 0);
      idle();
      w.mem_valid = 1'b1;
      w.mem_rd = '0;
      exp_ld = 32'h1111_2222;
      w.mem_funct3 = 3'b010;
      w.mem_rdata = 32'h1111_2222;
      tick();
      idle();
      tick();
      chk("rd0_ld_we", w.rf_we, 0);
      drain();

      // Reset in the middle of queued loads.
      w.chk_rs1 = 5'd3;
      w.chk_rs2 = 5'd4;
      w.ld_issue = 1'b1;
      w.ld_issue_rd = 5'd3;
      tick();
      w.ld_issue_rd = 5'd4;
      w.mem_valid = 1'b1;
      w.mem_rd = 5'd3;
      w.mem_funct3 = 3'b010;
      w.mem_rdata = 32'h3333_3333;
      exp_ld = 32'h3333_3333;
      tick();
      w.ld_issue = 1'b0;
      w.mem_rd = 5'd4;
      w.mem_rdata = 32'h4444_4444;
      exp_ld = 32'h4444_4444;
      tick();
      #2;
      do_reset();
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("post_rst_we", w.rf_we, 0);
      end
      chk("post_rst_pend1", w.hazard1, 0);
      chk("post_rst_pend2", w.hazard2, 0);
      w.chk_rs1 = '0;
      w.chk_rs2 = '0;

      // Forwarding versus hazard on an in-flight write.
      w.alu_valid = 1'b1;
      w.alu_rd = 5'd9;
      w.alu_data = 32'h9999_0009;
      tick();
      idle();
      w.chk_rs2 = 5'd9;
      #1;
`ifdef WB_BYPASS_EN
      chk("byp_fwd2", w.fwd2_valid, 1);
      chk("byp_haz2", w.hazard2, 0);
      chk("byp_data2", w.fwd2_data, 32'h9999_0009);
`else
      chk("nobyp_haz2", w.hazard2, 1);
      chk("nobyp_fwd2", w.fwd2_valid, 0);
      chk("nobyp_data2", w.fwd2_data, 0);
`endif
      tick();
      w.chk_rs2 = '0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter: DEPTH, 2, load-result FIFO entries (power of 2, >=2).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: alu_valid/alu_rd/alu_data  input  1/5/32  ALU result offer; alu_ready  output  1  accept.
REQ-005 SHALL have ports: ld_issue/ld_issue_rd  input  1/5  load issued, destination marked pending.
REQ-006 SHALL have ports: mem_valid/mem_rd/mem_funct3/mem_addr_lo/mem_rdata  input  1/5/3/2/32  load response; mem_ready  output  1  accept.
REQ-007 SHALL have ports: rf_we/rf_waddr/rf_wdata  output  1/5/32  registered register-file write port.
REQ-008 SHALL have ports: chk_rs1/chk_rs2  input  5  source query; hazard1/hazard2  output  1  stall request.
REQ-009 SHALL have ports: fwd1_valid/fwd2_valid  output  1, fwd1_data/fwd2_data  output  32  forwarding.

Function
REQ-010 Load response SHALL be accepted on a rising edge when mem_valid && mem_ready; mem_ready = FIFO not full.
REQ-011 Extension SHALL be applied at FIFO entry: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte lane = mem_addr_lo, halfword lane = mem_addr_lo[1]; other funct3 values SHALL be treated as LW.
REQ-012 Arbitration SHALL give the FIFO priority: FIFO non-empty -> pop head to write port, alu_ready=0; FIFO empty -> alu_ready=1.
REQ-013 All loads SHALL pass through the FIFO; no direct mem-to-port path (min load latency 2 edges to rf_we high).
REQ-014 Selected result SHALL appear on rf_we/rf_waddr/rf_wdata the cycle after its accepting edge, for exactly one cycle.
REQ-015 Results with rd=0 SHALL complete the handshake/pop but SHALL keep rf_we=0.
REQ-016 rf_we SHALL be 0 in any cycle with no selected result; rf_waddr/rf_wdata SHALL hold their last value.
REQ-017 Scoreboard SHALL be 32 pending bits; ld_issue with rd!=0 sets pending[rd] on the edge; bit 0 never set.
REQ-018 pending[rd] SHALL clear on the edge ending a cycle where rf_we=1 carries a load result to rd.
REQ-019 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-020 ALU writes SHALL NOT modify the scoreboard.
REQ-021 hazardN SHALL be combinational: pending[chk_rsN], plus (rf_we && rf_waddr==chk_rsN) when bypass is compiled out; chk_rsN=0 -> 0.
REQ-022 FIFO push and pop in the same cycle when full SHALL NOT occur (mem_ready=0); when non-full, both SHALL proceed with count unchanged.

Reset
REQ-023 resetn low SHALL immediately clear FIFO pointers/count, pending bits, rf_we, rf_waddr, rf_wdata to 0.
REQ-024 During and after reset, alu_ready=1, mem_ready=1, hazard*=0, fwd*=0.
REQ-025 Reset mid-operation SHALL discard queued results and pending marks with no rf_we pulse.

Configuration
REQ-026 Macro WB_BYPASS_EN defined: fwdN_valid = rf_we && rf_waddr==chk_rsN && chk_rsN!=0, fwdN_data = rf_wdata; that match SHALL NOT raise hazardN.
REQ-027 WB_BYPASS_EN undefined: ports exist, fwd*_valid=0, fwd*_data=0, match raises hazardN per REQ-021.

Verification
REQ-028 ALU: alu_valid, rd=5, data=0x12345678 with FIFO empty -> next cycle rf_we=1, waddr=5, wdata=0x12345678, one cycle.
REQ-029 Load: ld_issue rd=7, then mem rd=7, funct3=000, addr_lo=2, rdata=0x00800000 -> hazard1(chk_rs1=7)=1 until writeback; rf_wdata=0xFFFFFF80; pending[7] cleared after.
REQ-030 Collision: mem and ALU valid together -> load written first, alu_ready=0 until FIFO empty, then ALU written.
REQ-031 Fill: DEPTH+1 back-to-back loads with ALU idle -> mem_ready=0 after FIFO full; no result lost or reordered.
REQ-032 rd=0 ALU/load and mid-queue resetn pulse -> no rf_we, all pending 0, alu_ready=1 immediately.
REQ-033 Both builds: rf_we=1, waddr=9, chk_rs2=9 -> defined: fwd2_valid=1, hazard2=0; undefined: hazard2=1, fwd2_valid=0.
